// File: rtl/instruction_fetch_pkg.sv
// Shared fetch/decode definitions: default widths, special instruction words, fetch FSM states.
package instruction_fetch_pkg;
    localparam int ADDR_W_DEF = 12;
    localparam int INST_W_DEF = 19;

    localparam logic [INST_W_DEF-1:0] NOP       = '0;
    localparam logic [INST_W_DEF-1:0] HALT_INST = 19'h7FFFF;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_t;
endpackage

// File: rtl/fetch_pc_unit.sv
// PC register with incrementer and next-PC mux; redirect beats hold, hold beats advance.
module fetch_pc_unit #(
    parameter int ADDR_W   = 12,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_branch,
    input  logic              i_hold,
    input  logic [ADDR_W-1:0] i_target,
    output logic [ADDR_W-1:0] o_pc,
    output logic [ADDR_W-1:0] o_pc_inc
);
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_nxt;

    // Natural wrap at 2^ADDR_W
    assign o_pc_inc = r_pc + ADDR_W'(1);
    assign o_pc     = r_pc;

    always_comb begin
        w_pc_nxt = o_pc_inc;
        if (i_branch)    w_pc_nxt = i_target;
        else if (i_hold) w_pc_nxt = r_pc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_pc <= ADDR_W'(RESET_PC);
        else     r_pc <= w_pc_nxt;
    end
endmodule

// File: rtl/instruction_fetch.sv
// Zero-latency fetch stage: PC unit, IF/ID register and RUN/HALT FSM.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int INST_W   = INST_W_DEF,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [INST_W-1:0] imem_data,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [ADDR_W-1:0] pc,
    output logic [INST_W-1:0] if_id_inst,
    output logic [ADDR_W-1:0] if_id_pc1,
    output logic              if_id_valid,
    output logic              halted
);
    localparam logic [INST_W-1:0] L_NOP  = INST_W'(NOP);
    localparam logic [INST_W-1:0] L_HALT = INST_W'(HALT_INST);

    fetch_state_t      r_state;
    fetch_state_t      w_state_nxt;
    logic [ADDR_W-1:0] w_pc;
    logic [ADDR_W-1:0] w_pc_inc;
    logic              w_hold;
    logic              w_capture;

    fetch_pc_unit #(
        .ADDR_W  (ADDR_W),
        .RESET_PC(RESET_PC)
    ) u_pc (
        .clk     (clk),
        .rst     (rst),
        .i_branch(branch_taken),
        .i_hold  (w_hold),
        .i_target(branch_target),
        .o_pc    (w_pc),
        .o_pc_inc(w_pc_inc)
    );

    // imem_addr comes straight from the PC register, never from stall/branch logic
    assign imem_addr = w_pc;
    assign pc        = w_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_RUN;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        halted      = (r_state == ST_HALT);
        w_hold      = halted || stall;
        w_capture   = !branch_taken && !halted && !stall;
        if (branch_taken)
            w_state_nxt = ST_RUN;
        else if (w_capture && imem_data == L_HALT)
            w_state_nxt = ST_HALT;
    end

    // if_id_pc1 is left untouched on bubbles; consumers gate it with if_id_valid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_id_inst  <= L_NOP;
            if_id_pc1   <= '0;
            if_id_valid <= 1'b0;
        end else if (branch_taken || halted) begin
            if_id_inst  <= L_NOP;
            if_id_valid <= 1'b0;
        end else if (!stall) begin
            if_id_inst  <= imem_data;
            if_id_pc1   <= w_pc_inc;
            if_id_valid <= 1'b1;
        end
    end
endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench: expected IF/ID/PC state queued with each stimulus step, checked after the edge.
module tb_instruction_fetch;
    localparam int AW = 12;
    localparam int IW = 19;

    typedef struct {
        logic [AW-1:0] pc;
        logic [IW-1:0] inst;
        logic [AW-1:0] pc1;
        logic          valid;
        logic          halted;
        logic          chk_pc1;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] imem_addr;
    logic [IW-1:0] imem_data;
    logic          stall;
    logic          branch_taken;
    logic [AW-1:0] branch_target;
    logic [AW-1:0] pc;
    logic [IW-1:0] if_id_inst;
    logic [AW-1:0] if_id_pc1;
    logic          if_id_valid;
    logic          halted;

    logic [IW-1:0] mem [4096];
    exp_t          q[$];
    int            n_chk  = 0;
    int            n_pass = 0;

    instruction_fetch #(.ADDR_W(AW), .INST_W(IW), .RESET_PC(0)) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_addr    (imem_addr),
        .imem_data    (imem_data),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .pc           (pc),
        .if_id_inst   (if_id_inst),
        .if_id_pc1    (if_id_pc1),
        .if_id_valid  (if_id_valid),
        .halted       (halted)
    );

    always #5 clk = ~clk;
    assign imem_data = mem[imem_addr];

    function automatic logic [IW-1:0] m(input int i);
        return IW'(i * 3 + 7);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic chk_state(input string tag, input exp_t e);
        chk({tag, ".pc"},     32'(pc),          32'(e.pc));
        chk({tag, ".inst"},   32'(if_id_inst),  32'(e.inst));
        chk({tag, ".valid"},  32'(if_id_valid), 32'(e.valid));
        chk({tag, ".halted"}, 32'(halted),      32'(e.halted));
        if (e.chk_pc1) chk({tag, ".pc1"}, 32'(if_id_pc1), 32'(e.pc1));
    endtask

    // Called at a negedge: drive, queue expectation, check #1 after the edge, return at next negedge
    task automatic step(input string tag, input logic st, input logic br, input logic [AW-1:0] tgt,
                        input logic [AW-1:0] e_pc, input logic [IW-1:0] e_inst,
                        input logic [AW-1:0] e_pc1, input logic e_v, input logic e_h,
                        input logic e_cp1);
        exp_t e;
        stall         = st;
        branch_taken  = br;
        branch_target = tgt;
        q.push_back('{pc: e_pc, inst: e_inst, pc1: e_pc1, valid: e_v, halted: e_h, chk_pc1: e_cp1});
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            n_chk++;
            $error("FAIL %s scoreboard empty observed=0 expected=1", tag);
        end else begin
            e = q.pop_front();
            chk_state(tag, e);
        end
        @(negedge clk);
    endtask

    initial begin
        exp_t rv;
        for (int i = 0; i < 4096; i++) mem[i] = m(i);
        mem[5] = 19'h7FFFF;
        rv = '{pc: 0, inst: 0, pc1: 0, valid: 0, halted: 0, chk_pc1: 1};
        rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
        #12;
        chk_state("reset", rv);
        @(negedge clk);
        rst = 1'b0;

        // run A,B then stall two edges holding B, resume C,D
        step("runA",   0, 0, 0,    1,    m(0),  1,   1, 0, 1);
        step("runB",   0, 0, 0,    2,    m(1),  2,   1, 0, 1);
        step("stall1", 1, 0, 0,    2,    m(1),  2,   1, 0, 1);
        step("stall2", 1, 0, 0,    2,    m(1),  2,   1, 0, 1);
        step("runC",   0, 0, 0,    3,    m(2),  3,   1, 0, 1);
        step("runD",   0, 0, 0,    4,    m(3),  4,   1, 0, 1);
        // branch wins over stall
        step("brst",   1, 1, 100,  100,  0,     0,   0, 0, 0);
        step("br100",  0, 0, 0,    101,  m(100),101, 1, 0, 1);
        // wrap
        step("br4095", 0, 1, 4095, 4095, 0,     0,   0, 0, 0);
        step("wrap",   0, 0, 0,    0,    m(4095),0,  1, 0, 1);
        step("run0",   0, 0, 0,    1,    m(0),  1,   1, 0, 1);
        // HALT word under branch or stall must not halt
        step("br5",    0, 1, 5,    5,    0,     0,   0, 0, 0);
        step("brHalt", 0, 1, 5,    5,    0,     0,   0, 0, 0);
        step("stHalt", 1, 0, 0,    5,    0,     0,   0, 0, 0);
        // halt, then sticky bubbles even with stall
        step("halt",   0, 0, 0,    6,    19'h7FFFF, 6, 1, 1, 1);
        step("hbub1",  0, 0, 0,    6,    0,     0,   0, 1, 0);
        step("hbub2",  1, 0, 0,    6,    0,     0,   0, 1, 0);
        step("hexit",  0, 1, 0,    0,    0,     0,   0, 0, 0);
        step("rerun",  0, 0, 0,    1,    m(0),  1,   1, 0, 1);
        // halt again and clear it with an asynchronous reset pulse
        step("br5b",   0, 1, 5,    5,    0,     0,   0, 0, 0);
        step("halt2",  0, 0, 0,    6,    19'h7FFFF, 6, 1, 1, 1);
        step("hbub3",  0, 0, 0,    6,    0,     0,   0, 1, 0);
        rst = 1'b1;
        #1;
        chk_state("async_rst", rv);
        #1;
        rst = 1'b0;
        step("postrst",0, 0, 0,    1,    m(0),  1,   1, 0, 1);

        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 12: instruction address width (4096-word space).
REQ-002 The block SHALL have parameter INST_W, default 19: instruction word width.
REQ-003 The block SHALL have parameter RESET_PC, default 0: PC value loaded on reset.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The block SHALL have port imem_addr, output, ADDR_W bits: address to the instruction memory; equals pc.
REQ-007 The block SHALL have port imem_data, input, INST_W bits: word returned combinationally by the memory for imem_addr.
REQ-008 The block SHALL have port stall, input, 1 bit: hazard stall from decode; freezes pc and IF/ID.
REQ-009 The block SHALL have port branch_taken, input, 1 bit: redirect request from a later stage.
REQ-010 The block SHALL have port branch_target, input, ADDR_W bits: redirect address, valid when branch_taken=1.
REQ-011 The block SHALL have port pc, output, ADDR_W bits: current fetch PC.
REQ-012 The block SHALL have port if_id_inst, output, INST_W bits: registered fetched instruction.
REQ-013 The block SHALL have port if_id_pc1, output, ADDR_W bits: registered PC+1 of that instruction.
REQ-014 The block SHALL have port if_id_valid, output, 1 bit: 1 = if_id_inst is a real instruction; 0 = bubble.
REQ-015 The block SHALL have port halted, output, 1 bit: 1 when the FSM is in HALT.

Function
REQ-016 The block SHALL fetch with zero latency: the word on imem_data in cycle N SHALL be captured into IF/ID at the end of cycle N.
REQ-017 The block SHALL apply this per-edge priority: rst > branch_taken > HALT > stall > normal.
REQ-018 On normal operation, the block SHALL set pc <= pc+1 modulo 2^ADDR_W (4095 wraps to 0), if_id_inst <= imem_data, if_id_pc1 <= pc+1 (wrapped), and if_id_valid <= 1.
REQ-019 On stall=1 with branch_taken=0, the block SHALL hold pc, if_id_inst, if_id_pc1 and if_id_valid unchanged.
REQ-020 On branch_taken=1, the block SHALL set pc <= branch_target, if_id_inst <= NOP, if_id_valid <= 0 and leave if_id_pc1 don't-care, regardless of stall.
REQ-021 The block SHALL implement the FSM states RUN and HALT.
REQ-022 RUN -> HALT SHALL occur when a normal capture loads imem_data == HALT_INST: the HALT word is latched with valid=1 and pc still advances by 1 on that edge.
REQ-023 In HALT, the block SHALL hold pc, and each following edge SHALL load a NOP bubble (valid=0).
REQ-024 HALT -> RUN SHALL occur on branch_taken=1, applying REQ-020; otherwise HALT SHALL be sticky until rst.
REQ-025 The block SHALL drive halted=1 exactly in HALT.
REQ-026 A HALT_INST word arriving while stall=1 SHALL NOT cause a transition.
REQ-027 A HALT_INST word arriving while branch_taken=1 SHALL NOT cause a transition.
REQ-028 The block SHALL contain no combinational path from stall or branch_taken to imem_addr.

Reset
REQ-029 While rst=1, asynchronously and independent of clk, the block SHALL hold pc=RESET_PC, if_id_inst=NOP, if_id_pc1=0, if_id_valid=0, state=RUN and halted=0.
REQ-030 If rst asserts mid-stall or in HALT, all state SHALL return to REQ-029 values, and the first edge after deassertion SHALL fetch RESET_PC.

Structure
REQ-031 A shared package SHALL hold ADDR_W/INST_W defaults, NOP (all zeros), HALT_INST (all ones, 19'h7FFFF) and the RUN/HALT state enumeration, for reuse by decode.
REQ-032 The block SHALL instantiate one sub-module, fetch_pc_unit, holding the PC register, the incrementer and the next-PC mux; the IF/ID register and the FSM SHALL remain in instruction_fetch.

Verification
REQ-033 Reset then run: memory words 0..3 = A,B,C,D, 4 edges -> IF/ID shows A,B,C,D with if_id_pc1 = 1,2,3,4, valid=1, pc=4.
REQ-034 Stall: stall=1 for 2 cycles while if_id_inst=B -> pc and IF/ID are unchanged for 2 edges, then fetch resumes at C.
REQ-035 Branch with stall: branch_taken=1, branch_target=100, stall=1 -> next edge pc=100 and valid=0; the following edge fetches word 100 with valid=1.
REQ-036 Wrap: pc=4095 -> next pc=0 and if_id_pc1=0.
REQ-037 Halt: word 5 = 19'h7FFFF -> captured with valid=1, halted=1, pc=6 held, bubbles follow; branch_taken to 0 -> halted=0, pc=0.
REQ-038 Async reset: rst pulsed between edges while in HALT -> outputs take reset values immediately, with no clk edge required.
